memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Stage directly downstream of the execute stage in the single-cycle-derived RV32I core.
- Consumes the execute result (ALU output / effective address), the rs2 value and the instruction.
- Performs loads and stores over a ready-handshaked data-memory port, with byte-lane steering and load sign/zero extension.
- Delivers a registered write-back packet (data, rd, enable) plus exception flags to the register-file write-back.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles dmem_req may stay high without dmem_ready before the access aborts with a bus error; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on rising clk)
- in_valid  in  1  execute-stage packet valid
- in_ready  out  1  stage can accept a packet (high only in IDLE)
- instr  in  32  instruction of the packet
- pc  in  32  pc of the packet; passed through for debug
- EXECUTE_OUT  in  32  ALU result / effective address
- REG_VALUE_IN2  in  32  rs2 value (store data)
- MemtoReg  in  1  1 = load/store class, 0 = ALU write-back
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {EXECUTE_OUT[31:2],2'b00}
- dmem_wstrb  out  4  byte write strobes; 0 for reads
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- out_valid  out  1  one-cycle pulse: write-back packet valid
- WB_EN  out  1  register write enable
- WB_RD  out  5  destination register, instr[11:7]
- WB_DATA  out  32  write-back value
- WB_PC  out  32  pc of completed packet
- misalign  out  1  with out_valid: misaligned access, no bus access made
- bus_err  out  1  with out_valid: access timed out

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs and the timeout counter are 0; in_ready goes to 1 in the first non-reset cycle. A reset in MEM or DONE drops dmem_req at that edge and discards the packet; no out_valid follows.
- Accept: in_valid && in_ready at a rising edge latches instr, pc, EXECUTE_OUT and REG_VALUE_IN2 internally. Upstream holds its inputs while in_ready=0.
- Classify by opcode instr[6:0]:
  - Load 0000011 (funct3 000/001/010/100/101).
  - Store 0100011 (funct3 000/001/010).
  - Write-back class: 0110111, 0010111, 0010011, 0110011, 1101111, 1100111.
  - Everything else (branch, fence, system, undefined): no write-back.
  - MemtoReg is ignored for classification; a mismatch with the opcode has no effect.
- States:
  - IDLE: accept a packet.
    - Non-memory op → DONE, WB_DATA=EXECUTE_OUT.
    - Memory op misaligned → DONE with misalign=1.
    - Memory op aligned → MEM.
  - MEM: dmem_req=1, with dmem_addr/we/wstrb/wdata held stable.
    - dmem_ready=1 → capture/format rdata and go to DONE.
    - Otherwise increment the counter; when counter == TIMEOUT_CYCLES-1 with no ready → DONE with bus_err=1.
  - DONE: out_valid=1 for exactly one cycle, then IDLE.
- Latency from the accept edge to out_valid high:
  - Non-memory op: 1 cycle.
  - Memory op: 2 + (wait cycles before ready). dmem_ready in the first MEM cycle gives out_valid 2 cycles after accept.
- Alignment: halfword (lh/lhu/sh) requires addr[0]=0; word (lw/sw) requires addr[1:0]=0; byte access is always aligned.
- Store lanes, with lane = addr[1:0]:
  - sb: wstrb = 0001<<lane; wdata = {4{rs2[7:0]}}.
  - sh: wstrb = 0011<<lane; wdata = {2{rs2[15:0]}}.
  - sw: wstrb = 1111; wdata = rs2.
- Loads: select byte rdata[8*lane+:8] or halfword rdata[8*lane+:16]. lb/lh sign-extend to 32; lbu/lhu zero-extend; lw passes rdata unchanged.
- WB_EN=1 only for a load or write-back-class op with rd≠0 and misalign=0 and bus_err=0. Stores never write back.
- WB_EN, WB_RD, WB_DATA, WB_PC, misalign and bus_err are valid only while out_valid=1. They return to 0 the cycle after out_valid.
- dmem_req never asserts for misaligned accesses, non-memory ops or during reset. dmem_ready outside MEM is ignored.

Test Plan:
- Reset held 3 cycles during MEM → dmem_req=0 after the first reset edge; no out_valid; in_ready=1 after release.
- addi rd=5, EXECUTE_OUT=0x0000_1234 → out_valid 1 cycle after accept; WB_EN=1, WB_RD=5, WB_DATA=0x1234, dmem_req never high.
- lb, addr=0x103, rdata=0x80AB_CDEF, ready after 2 wait cycles → dmem_addr=0x100, wstrb=0; WB_DATA=0xFFFF_FF80 with out_valid 4 cycles after accept. Repeat with lbu → 0x0000_0080.
- sh, addr=0x202, rs2=0xDEAD_BEEF, immediate ready → dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, WB_EN=0.
- lw, addr=0x301 → out_valid with misalign=1, WB_EN=0; dmem_req stays 0.
- sw with dmem_ready tied 0, TIMEOUT_CYCLES=4 → dmem_req high exactly 4 cycles, then out_valid with bus_err=1; the next packet is accepted normally.

Source files
------------

// File: rtl/memory_access.sv
// RV32I memory stage: steers loads/stores onto a ready-handshaked port and registers the write-back packet.
// Latency 1 cycle (non-memory) or 2 + wait cycles (memory); in_ready is low from accept through out_valid.
module memory_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] EXECUTE_OUT,
    input  logic [31:0] REG_VALUE_IN2,
    input  logic        MemtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        out_valid,
    output logic        WB_EN,
    output logic [4:0]  WB_RD,
    output logic [31:0] WB_DATA,
    output logic [31:0] WB_PC,
    output logic        misalign,
    output logic        bus_err
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        accept, in_ld, in_st, in_mem, in_mis, timeout;
    logic        ld_q, ld_d, st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, rs2_q, rs2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_en_q, wb_en_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
    logic [15:0] rdata_sh;
    logic [31:0] load_val, st_wdata;
    logic [3:0]  st_strb;
    logic        unused_ok;

    function automatic logic f_load(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_LOAD) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    function automatic logic f_store(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_STORE) && (f3 inside {3'b000, 3'b001, 3'b010});
    endfunction

    function automatic logic f_wb(input logic [6:0] op);
        return op inside {7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic f_misal(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // MemtoReg is redundant with the opcode and deliberately ignored.
    assign unused_ok = ^{MemtoReg, instr[31:15]};
    assign in_ld     = f_load(instr[6:0], instr[14:12]);
    assign in_st     = f_store(instr[6:0], instr[14:12]);
    assign in_mem    = in_ld || in_st;
    assign in_mis    = in_mem && f_misal(instr[14:12], EXECUTE_OUT[1:0]);
    assign accept    = in_valid && in_ready;
    assign timeout   = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (in_mem && !in_mis) ? S_MEM : S_DONE;
            S_MEM:   if (dmem_ready || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE) && rst;
        dmem_req   = (state_q == S_MEM);
        dmem_we    = dmem_req && st_q;
        dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        dmem_wstrb = (dmem_req && st_q) ? st_strb : 4'h0;
        dmem_wdata = (dmem_req && st_q) ? st_wdata : 32'h0;
        out_valid  = (state_q == S_DONE);
    end

    // Lane steering: loads shift the addressed lane down to bit 0, stores replicate across lanes.
    always_comb begin
        rdata_sh = 16'(dmem_rdata >> {addr_q[1:0], 3'b000});
        load_val = dmem_rdata;
        st_strb  = 4'hF;
        st_wdata = rs2_q;
        case (f3_q)
            3'b000:  load_val = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_val = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_val = {24'h0, rdata_sh[7:0]};
            3'b101:  load_val = {16'h0, rdata_sh[15:0]};
            default: load_val = dmem_rdata;
        endcase
        case (f3_q[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << addr_q[1:0];
                st_wdata = {4{rs2_q[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << addr_q[1:0];
                st_wdata = {2{rs2_q[15:0]}};
            end
            default: begin
                st_strb  = 4'hF;
                st_wdata = rs2_q;
            end
        endcase
    end

    always_comb begin
        ld_d       = ld_q;
        st_d       = st_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        rs2_d      = rs2_q;
        cnt_d      = 8'd0;
        wb_en_d    = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'h0;
        wb_pc_d    = 32'h0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ld_d   = in_ld;
                    st_d   = in_st;
                    f3_d   = instr[14:12];
                    rd_d   = instr[11:7];
                    pc_d   = pc;
                    addr_d = EXECUTE_OUT;
                    rs2_d  = REG_VALUE_IN2;
                    // Packets that skip the bus complete straight from IDLE.
                    if (!in_mem || in_mis) begin
                        wb_en_d    = f_wb(instr[6:0]) && (instr[11:7] != 5'd0);
                        wb_rd_d    = instr[11:7];
                        wb_data_d  = EXECUTE_OUT;
                        wb_pc_d    = pc;
                        misalign_d = in_mis;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ready || timeout) begin
                    wb_rd_d = rd_q;
                    wb_pc_d = pc_q;
                end
                if (dmem_ready) begin
                    wb_en_d   = ld_q && (rd_q != 5'd0);
                    wb_data_d = ld_q ? load_val : 32'h0;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            pc_q       <= 32'h0;
            addr_q     <= 32'h0;
            rs2_q      <= 32'h0;
            cnt_q      <= 8'd0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
            wb_pc_q    <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            ld_q       <= ld_d;
            st_q       <= st_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            rs2_q      <= rs2_d;
            cnt_q      <= cnt_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign WB_EN    = wb_en_q;
    assign WB_RD    = wb_rd_q;
    assign WB_DATA  = wb_data_q;
    assign WB_PC    = wb_pc_q;
    assign misalign = misalign_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vector table, reset-in-MEM sequence, randomized ops against a reference model.
module tb_memory_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, MemtoReg;
    logic [31:0] instr, pc, EXECUTE_OUT, REG_VALUE_IN2;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        out_valid, WB_EN, misalign, bus_err;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA, WB_PC;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .EXECUTE_OUT(EXECUTE_OUT), .REG_VALUE_IN2(REG_VALUE_IN2),
        .MemtoReg(MemtoReg), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .out_valid(out_valid), .WB_EN(WB_EN), .WB_RD(WB_RD),
        .WB_DATA(WB_DATA), .WB_PC(WB_PC), .misalign(misalign), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] ex;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          waits;
        int          lat;
        logic        wb_en;
        logic [31:0] data;
        logic        dchk;
        logic        mis;
        logic        berr;
        int          reqc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        int          lat;
        int          reqc;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        mis;
        logic        berr;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        unstable;
        logic        post_ok;
    } res_t;

    logic [6:0] wb_ops [6]    = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67};
    logic [6:0] other_ops [4] = '{7'h63, 7'h0F, 7'h73, 7'h7F};
    logic [2:0] bad_ld_f3 [3] = '{3'd3, 3'd6, 3'd7};

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {12'h0, 5'd1, f3, rd, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: works from access size, lane and wait count, not from any state machine.
    function automatic vec_t model(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] ex,
                                   input logic [31:0] rs2, input logic [31:0] rdata, input int waits);
        vec_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic ld, st, wbc;
        int size, lane;
        logic [31:0] v;
        op = ins[6:0];
        f3 = ins[14:12];
        e = '{ins, pcv, ex, rs2, rdata, waits, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 4'h0, 32'h0};
        ld   = (op == 7'h03) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        st   = (op == 7'h23) && (f3 <= 3'd2);
        wbc  = (op == 7'h37 || op == 7'h17 || op == 7'h13 || op == 7'h33 || op == 7'h6F || op == 7'h67);
        size = 1 << int'(f3[1:0]);
        lane = int'(ex[1:0]);
        e.mis = (ld || st) && ((ex % 32'(size)) != 32'h0);
        if ((ld || st) && !e.mis) begin
            e.addr = ex - 32'(lane);
            e.we   = st;
            if (waits >= 0 && waits < TO) begin
                e.reqc = waits + 1;
                e.lat  = waits + 2;
            end else begin
                e.reqc = TO;
                e.lat  = TO + 1;
                e.berr = 1'b1;
            end
            if (st) begin
                e.strb  = 4'(((1 << size) - 1) << lane);
                e.wdata = (size == 1) ? 32'(rs2[7:0]) * 32'h01010101 :
                          (size == 2) ? 32'(rs2[15:0]) * 32'h00010001 : rs2;
            end
            if (ld && !e.berr) begin
                if (size == 4) begin
                    v = rdata;
                end else begin
                    v = (rdata >> (8 * lane)) & 32'((1 << (8 * size)) - 1);
                    if (f3[2] == 1'b0 && ((v >> (8 * size - 1)) & 32'h1) == 32'h1)
                        v = v - 32'(1 << (8 * size));
                end
                e.data  = v;
                e.dchk  = 1'b1;
                e.wb_en = (ins[11:7] != 5'd0);
            end
        end else begin
            e.lat   = 1;
            e.data  = ex;
            e.dchk  = !e.mis;
            e.wb_en = wbc && (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    // Called at a negedge; drives one packet, plays the memory, returns at the negedge after out_valid.
    task automatic run_txn(input vec_t v, input bit noise, output res_t r);
        int guard;
        bit done;
        r = '{-1, 0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        instr = v.ins; pc = v.pc; EXECUTE_OUT = v.ex; REG_VALUE_IN2 = v.rs2;
        MemtoReg = 1'($urandom);
        in_valid = 1'b1;
        dmem_ready = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (dmem_req) begin
                if (r.reqc == 0) begin
                    r.addr = dmem_addr; r.we = dmem_we; r.strb = dmem_wstrb; r.wdata = dmem_wdata;
                end else if (r.addr !== dmem_addr || r.we !== dmem_we || r.strb !== dmem_wstrb || r.wdata !== dmem_wdata) begin
                    r.unstable = 1'b1;
                end
                r.reqc++;
                dmem_ready = (v.waits >= 0) && (r.reqc - 1 == v.waits);
                dmem_rdata = dmem_ready ? v.rdata : $urandom;
            end else begin
                dmem_ready = noise ? 1'($urandom) : 1'b0;
                dmem_rdata = $urandom;
            end
            if (out_valid) begin
                r.lat = k; r.wb_en = WB_EN; r.rd = WB_RD; r.data = WB_DATA; r.pc = WB_PC;
                r.mis = misalign; r.berr = bus_err;
                done = 1'b1;
            end
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        r.post_ok = !out_valid && !WB_EN && WB_RD == 5'd0 && WB_DATA == 32'h0 && WB_PC == 32'h0 &&
                    !misalign && !bus_err && in_ready && !dmem_req;
    endtask

    task automatic check_txn(input string tag, input vec_t e, input res_t r);
        chk({tag, ".latency"}, r.lat, e.lat);
        chk({tag, ".WB_EN"}, 32'(r.wb_en), 32'(e.wb_en));
        chk({tag, ".WB_RD"}, 32'(r.rd), 32'(e.ins[11:7]));
        chk({tag, ".WB_PC"}, r.pc, e.pc);
        chk({tag, ".misalign"}, 32'(r.mis), 32'(e.mis));
        chk({tag, ".bus_err"}, 32'(r.berr), 32'(e.berr));
        chk({tag, ".req_cycles"}, r.reqc, e.reqc);
        if (e.dchk) chk({tag, ".WB_DATA"}, r.data, e.data);
        if (e.reqc > 0) begin
            chk({tag, ".dmem_addr"}, r.addr, e.addr);
            chk({tag, ".dmem_we"}, 32'(r.we), 32'(e.we));
            chk({tag, ".dmem_wstrb"}, 32'(r.strb), 32'(e.strb));
            if (e.we) chk({tag, ".dmem_wdata"}, r.wdata, e.wdata);
            chk({tag, ".req_stable"}, 32'(r.unstable), 32'h0);
        end
        chk({tag, ".post_clear"}, 32'(r.post_ok), 32'h1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [14];
        vec_t e;
        res_t r;
        logic seen_ov, seen_req;

        // ins, pc, ex, rs2, rdata, waits | lat, wb_en, data, dchk, mis, berr, reqc, addr, we, strb, wdata
        vecs[0]  = '{mk(7'h13, 3'd0, 5'd5), 32'h1000, 32'h0000_1234, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 4'h0, 32'h0};
        vecs[1]  = '{mk(7'h03, 3'd0, 5'd6), 32'h1004, 32'h0000_0103, 32'h0, 32'h80AB_CDEF, 2, 4, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 3, 32'h100, 1'b0, 4'h0, 32'h0};
        vecs[2]  = '{mk(7'h03, 3'd4, 5'd6), 32'h1008, 32'h0000_0103, 32'h0, 32'h80AB_CDEF, 2, 4, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 3, 32'h100, 1'b0, 4'h0, 32'h0};
        vecs[3]  = '{mk(7'h23, 3'd1, 5'd0), 32'h100C, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 0, 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 32'h200, 1'b1, 4'b1100, 32'hBEEF_BEEF};
        vecs[4]  = '{mk(7'h03, 3'd2, 5'd7), 32'h1010, 32'h0000_0301, 32'h0, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 4'h0, 32'h0};
        vecs[5]  = '{mk(7'h23, 3'd2, 5'd0), 32'h1014, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, -1, 5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4, 32'h400, 1'b1, 4'hF, 32'hCAFE_F00D};
        vecs[6]  = '{mk(7'h03, 3'd1, 5'd8), 32'h1018, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 1, 3, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 2, 32'h400, 1'b0, 4'h0, 32'h0};
        vecs[7]  = '{mk(7'h03, 3'd5, 5'd8), 32'h101C, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 1, 3, 1'b1, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 2, 32'h400, 1'b0, 4'h0, 32'h0};
        vecs[8]  = '{mk(7'h03, 3'd2, 5'd0), 32'h1020, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 5, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 4, 32'h10, 1'b0, 4'h0, 32'h0};
        vecs[9]  = '{mk(7'h63, 3'd0, 5'd0), 32'h1024, 32'h0000_ABCD, 32'h0, 32'h0, 0, 1, 1'b0, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 4'h0, 32'h0};
        vecs[10] = '{mk(7'h23, 3'd0, 5'd0), 32'h1028, 32'h0000_0501, 32'h1234_56A5, 32'h0, 0, 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 32'h500, 1'b1, 4'b0010, 32'hA5A5_A5A5};
        vecs[11] = '{mk(7'h37, 3'd0, 5'd7), 32'h102C, 32'h1234_5000, 32'h0, 32'h0, 0, 1, 1'b1, 32'h1234_5000, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 4'h0, 32'h0};
        vecs[12] = '{mk(7'h23, 3'd1, 5'd0), 32'h1030, 32'h0000_0203, 32'h1111_2222, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 4'h0, 32'h0};
        vecs[13] = '{mk(7'h03, 3'd2, 5'd9), 32'h1034, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1, 32'h20, 1'b0, 4'h0, 32'h0};

        rst = 1'b0; in_valid = 1'b0; instr = 32'h0; pc = 32'h0; EXECUTE_OUT = 32'h0;
        REG_VALUE_IN2 = 32'h0; MemtoReg = 1'b0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        chk("reset.dmem_req", 32'(dmem_req), 32'h0);
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk("reset.WB_EN", 32'(WB_EN), 32'h0);
        chk("reset.WB_DATA", WB_DATA, 32'h0);
        chk("reset.flags", 32'({misalign, bus_err, dmem_wstrb}), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset.in_ready_after", 32'(in_ready), 32'h1);

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], 1'b0, r);
            check_txn($sformatf("vec%0d", i), vecs[i], r);
        end

        // Reset asserted for 3 edges while a never-answered access is in flight.
        instr = mk(7'h03, 3'd2, 5'd3); pc = 32'h2000; EXECUTE_OUT = 32'h700; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mem.req_before", 32'(dmem_req), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem.req_dropped", 32'(dmem_req), 32'h0);
        seen_ov = out_valid;
        seen_req = dmem_req;
        repeat (2) begin
            @(negedge clk);
            seen_ov |= out_valid;
            seen_req |= dmem_req;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mem.in_ready", 32'(in_ready), 32'h1);
        repeat (5) begin
            @(negedge clk);
            seen_ov |= out_valid;
            seen_req |= dmem_req;
        end
        chk("rst_mem.no_out_valid", 32'(seen_ov), 32'h0);
        chk("rst_mem.no_req", 32'(seen_req), 32'h0);
        run_txn(vecs[0], 1'b0, r);
        check_txn("rst_mem.recover", vecs[0], r);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ins;
            logic [6:0] op;
            logic [2:0] f3;
            int cls;
            ins = $urandom;
            f3  = 3'($urandom);
            cls = int'($urandom_range(0, 5));
            case (cls)
                0, 1:    begin op = 7'h03; f3 = (f3 == 3'd3 || f3 >= 3'd6) ? 3'd2 : f3; end
                2:       begin op = 7'h23; f3 = 3'($urandom_range(0, 2)); end
                3:       op = wb_ops[$urandom_range(0, 5)];
                4:       op = other_ops[$urandom_range(0, 3)];
                default: begin op = 7'h03; f3 = bad_ld_f3[$urandom_range(0, 2)]; end
            endcase
            ins[6:0]   = op;
            ins[14:12] = f3;
            e = model(ins, $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 6)) - 1);
            run_txn(e, 1'b1, r);
            check_txn($sformatf("rnd%0d", i), e, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
